// File: rtl/score_display.sv
// Seven-segment driver for score/high-score: shift-add-3 BCD converter, digit scan and collision blink.
// Define SCORE_DISPLAY_HISCORE_EN to build the high-score registers and show them on digits 2-3.
module score_display #(
  parameter int REFRESH_BITS = 16,
  parameter int BLINK_BITS   = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] total_score,
  input  logic       colision,
  output logic [3:0] an,
  output logic [7:0] seg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [REFRESH_BITS-1:0] REF_ONE   = {{(REFRESH_BITS-1){1'b0}}, 1'b1};
  localparam logic [BLINK_BITS-1:0]   BLINK_ONE = {{(BLINK_BITS-1){1'b0}}, 1'b1};

  function automatic logic [3:0] add3(input logic [3:0] nib);
    if (nib >= 4'd5) begin
      return nib + 4'd3;
    end else begin
      return nib;
    end
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] dig);
    case (dig)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  state_e                  state_q, state_d;
  logic [5:0]              src_q, src_d;
  logic [5:0]              sh_q, sh_d;
  logic [7:0]              bcd_q, bcd_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [7:0]              score_bcd_q, score_bcd_d;
`ifdef SCORE_DISPLAY_HISCORE_EN
  logic [5:0]              hi_bin_q, hi_bin_d;
  logic [7:0]              hi_bcd_q, hi_bcd_d;
`endif
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [BLINK_BITS-1:0]   blink_q, blink_d;
  logic [1:0]              digit_q, digit_d;
  logic [3:0]              an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic                    blink_on_s;

  // Binary-to-BCD converter FSM: capture, six adjust-and-shift iterations, commit.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    sh_d        = sh_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    score_bcd_d = score_bcd_q;
`ifdef SCORE_DISPLAY_HISCORE_EN
    hi_bin_d    = hi_bin_q;
    hi_bcd_d    = hi_bcd_q;
`endif
    case (state_q)
      IDLE: begin
        if (total_score != src_q) begin
          src_d   = total_score;
          sh_d    = total_score;
          bcd_d   = 8'h00;
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bcd_d = ({add3(bcd_q[7:4]), add3(bcd_q[3:0])} << 1) | {7'd0, sh_q[5]};
        sh_d  = {sh_q[4:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        score_bcd_d = bcd_q;
`ifdef SCORE_DISPLAY_HISCORE_EN
        if (src_q > hi_bin_q) begin
          hi_bin_d = src_q;
          hi_bcd_d = bcd_q;
        end else begin
          hi_bin_d = hi_bin_q;
          hi_bcd_d = hi_bcd_q;
        end
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running refresh/blink counters and digit index; output digit/segment selection.
  always_comb begin
    refresh_d  = refresh_q + REF_ONE;
    blink_d    = blink_q + BLINK_ONE;
    digit_d    = digit_q;
    an_d       = 4'b1111;
    seg_d      = 8'hFF;
    blink_on_s = colision & blink_q[BLINK_BITS-1];
    if (&refresh_q) begin
`ifdef SCORE_DISPLAY_HISCORE_EN
      digit_d = digit_q + 2'd1;
`else
      digit_d = (digit_q == 2'd0) ? 2'd1 : 2'd0;
`endif
    end else begin
      digit_d = digit_q;
    end
    case (digit_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = blink_on_s ? 8'hFF : seg7(score_bcd_q[3:0]);
      end
      2'd1: begin
        an_d  = 4'b1101;
        seg_d = (blink_on_s || (score_bcd_q[7:4] == 4'd0)) ? 8'hFF : seg7(score_bcd_q[7:4]);
      end
`ifdef SCORE_DISPLAY_HISCORE_EN
      2'd2: begin
        an_d  = 4'b1011;
        seg_d = seg7(hi_bcd_q[3:0]);
      end
      2'd3: begin
        an_d  = 4'b0111;
        seg_d = (hi_bcd_q[7:4] == 4'd0) ? 8'hFF : seg7(hi_bcd_q[7:4]);
      end
`endif
      default: begin
        an_d  = 4'b1111;
        seg_d = 8'hFF;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      src_q       <= 6'd0;
      sh_q        <= 6'd0;
      bcd_q       <= 8'h00;
      cnt_q       <= 3'd0;
      score_bcd_q <= 8'h00;
`ifdef SCORE_DISPLAY_HISCORE_EN
      hi_bin_q    <= 6'd0;
      hi_bcd_q    <= 8'h00;
`endif
      refresh_q   <= '0;
      blink_q     <= '0;
      digit_q     <= 2'd0;
      an_q        <= 4'b1111;
      seg_q       <= 8'hFF;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      sh_q        <= sh_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      score_bcd_q <= score_bcd_d;
`ifdef SCORE_DISPLAY_HISCORE_EN
      hi_bin_q    <= hi_bin_d;
      hi_bcd_q    <= hi_bcd_d;
`endif
      refresh_q   <= refresh_d;
      blink_q     <= blink_d;
      digit_q     <= digit_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display with a decimal-arithmetic reference model of the display.
module tb_score_display;

  localparam int RB = 4;
  localparam int BB = 6;
`ifdef SCORE_DISPLAY_HISCORE_EN
  localparam bit HI_EN = 1'b1;
  localparam int NDIG  = 4;
`else
  localparam bit HI_EN = 1'b0;
  localparam int NDIG  = 2;
`endif

  logic       clk;
  logic       reset;
  logic [5:0] total_score;
  logic       colision;
  logic [3:0] an;
  logic [7:0] seg;

  int n_tests;
  int n_fail;

  // reference model state
  int m_t;
  int m_src;
  int m_score;
  int m_hi;
  int m_busy;

  logic [7:0] codes [10];

  score_display #(.REFRESH_BITS(RB), .BLINK_BITS(BB)) dut (
    .clk         (clk),
    .reset       (reset),
    .total_score (total_score),
    .colision    (colision),
    .an          (an),
    .seg         (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    logic [3:0] ea;
    logic [7:0] es;
    int         d;
    bit         blink;
    if (!reset) begin
      ea = 4'hF;
      es = 8'hFF;
      m_t = 0; m_src = 0; m_score = 0; m_hi = 0; m_busy = 0;
    end else begin
      d     = (m_t / (1 << RB)) % NDIG;
      blink = colision && (((m_t % (1 << BB)) / (1 << (BB - 1))) == 1);
      ea    = ~(4'b0001 << d);
      case (d)
        0:       es = blink ? 8'hFF : codes[m_score % 10];
        1:       es = (blink || (m_score / 10 == 0)) ? 8'hFF : codes[m_score / 10];
        2:       es = codes[m_hi % 10];
        3:       es = (m_hi / 10 == 0) ? 8'hFF : codes[m_hi / 10];
        default: es = 8'hFF;
      endcase
      m_t++;
      if (m_busy == 0) begin
        if (int'(total_score) != m_src) begin
          m_src  = int'(total_score);
          m_busy = 7;
        end
      end else if (m_busy == 1) begin
        m_score = m_src;
        if (HI_EN && m_src > m_hi) m_hi = m_src;
        m_busy = 0;
      end else begin
        m_busy--;
      end
    end
    @(posedge clk);
    #1;
    n_tests++;
    assert (an === ea) else begin
      n_fail++;
      $error("FAIL an t=%0d observed=%b expected=%b", m_t, an, ea);
    end
    n_tests++;
    assert (seg === es) else begin
      n_fail++;
      $error("FAIL seg t=%0d observed=%h expected=%h", m_t, seg, es);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_digit(input int d, input logic [7:0] exp_seg, input string tag);
    logic [3:0] want;
    bit         found;
    want  = ~(4'b0001 << d);
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      if (an === want) found = 1'b1;
    end
    n_tests++;
    assert (found && seg === exp_seg) else begin
      n_fail++;
      $error("FAIL %s found=%0d observed=%h expected=%h", tag, found, seg, exp_seg);
    end
  endtask

  initial begin
    codes = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    n_tests = 0; n_fail = 0;
    m_t = 0; m_src = 0; m_score = 0; m_hi = 0; m_busy = 0;
    reset = 1'b0; total_score = 6'd0; colision = 1'b0;

    run(3);
    reset = 1'b1;
    wait_digit(0, 8'hC0, "rst_d0");
    wait_digit(1, 8'hFF, "rst_d1");

    total_score = 6'd42;
    run(10);
    wait_digit(0, 8'hA4, "s42_d0");
    wait_digit(1, 8'h99, "s42_d1");

    total_score = 6'd63;
    run(10);
    wait_digit(0, 8'hB0, "s63_d0");
    wait_digit(1, 8'h82, "s63_d1");

    total_score = 6'd9;
    run(10);
    wait_digit(0, 8'h90, "s9_d0");
    wait_digit(1, 8'hFF, "s9_d1");

    total_score = 6'd10;
    run(2);
    total_score = 6'd11;
    run(20);
    wait_digit(0, 8'hF9, "s11_d0");
    wait_digit(1, 8'hF9, "s11_d1");

    reset = 1'b0;
    run(2);
    reset = 1'b1;
    total_score = 6'd30;
    run(12);
    total_score = 6'd12;
    run(12);
    wait_digit(0, 8'hA4, "s12_d0");
    wait_digit(1, 8'hF9, "s12_d1");
`ifdef SCORE_DISPLAY_HISCORE_EN
    wait_digit(2, 8'hC0, "hi30_d2");
    wait_digit(3, 8'hB0, "hi30_d3");
    total_score = 6'd31;
    run(12);
    wait_digit(2, 8'hF9, "hi31_d2");
    wait_digit(3, 8'hB0, "hi31_d3");
`endif

    colision = 1'b1;
    run(200);
    colision = 1'b0;

    for (int k = 0; k < 300; k++) begin
      total_score = 6'($urandom_range(0, 63));
      colision    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
      end
      run(int'($urandom_range(1, 20)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
